// File: rtl/iot_monitor_pkg.sv
// Shared types and helpers for the multi-channel active-device monitor.
package iot_monitor_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ALARM = 1'b1
    } alarm_state_t;

    // Width of the aggregate total: holds NCH*(2^WIDTH-1) without overflow.
    function automatic int unsigned total_width(input int unsigned width, input int unsigned nch);
        return width + 32'($clog2(nch)) + 32'd1;
    endfunction

endpackage

// File: rtl/iot_chan_counter.sv
// One up/down device counter with saturate-or-wrap limits and sticky ovf/udf flags.
module iot_chan_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             change,
    input  logic             on_off,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             udf
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             inc, dec, at_max, at_min;

    assign inc    = change & on_off;
    assign dec    = change & ~on_off;
    assign at_max = (count_q == {WIDTH{1'b1}});
    assign at_min = (count_q == {WIDTH{1'b0}});

    // Next count and flags; a flag-set event in the same cycle as clr_flags wins.
    always_comb begin
        count_d = count_q;
        if (inc) begin
            if (!(at_max && SATURATE)) count_d = count_q + WIDTH'(1);
        end else if (dec) begin
            if (!(at_min && SATURATE)) count_d = count_q - WIDTH'(1);
        end
        ovf_d = (ovf_q & ~clr_flags) | (inc & at_max);
        udf_d = (udf_q & ~clr_flags) | (dec & at_min);
    end

    // Counter and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: rtl/iot_monitor_multi.sv
// Multi-channel active-device monitor: per-channel counters, registered total, hysteresis alarm.
module iot_monitor_multi
    import iot_monitor_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NCH      = 4,
    parameter bit          SATURATE = 1'b1,
    parameter int unsigned ALARM_HI = 16,
    parameter int unsigned ALARM_LO = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NCH-1:0]             change,
    input  logic [NCH-1:0]             on_off,
    input  logic                       clr_flags,
    output logic [NCH*WIDTH-1:0]       chan_count,
    output logic [WIDTH+$clog2(NCH):0] total_count,
    output logic [NCH-1:0]             ovf,
    output logic [NCH-1:0]             udf,
    output logic                       alarm
);

    localparam int unsigned TW = total_width(WIDTH, NCH);

    logic [TW-1:0] total_q, total_d;
    alarm_state_t  state_q, state_d;
    logic          alarm_q;

    // One independent counter per channel.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        iot_chan_counter #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .change    (change[i]),
            .on_off    (on_off[i]),
            .clr_flags (clr_flags),
            .count     (chan_count[i*WIDTH +: WIDTH]),
            .ovf       (ovf[i]),
            .udf       (udf[i])
        );
    end

    // Sum of the current channel counts.
    always_comb begin
        total_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            total_d = total_d + TW'(chan_count[i*WIDTH +: WIDTH]);
        end
    end

    // Alarm next state from the registered total; the band between LO and HI holds.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (total_q >= TW'(ALARM_HI)) state_d = ALARM;
            ALARM:   if (total_q <= TW'(ALARM_LO)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Total, FSM state and alarm output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            total_q <= '0;
            state_q <= IDLE;
            alarm_q <= 1'b0;
        end else begin
            total_q <= total_d;
            state_q <= state_d;
            alarm_q <= (state_d == ALARM);
        end
    end

    assign total_count = total_q;
    assign alarm       = alarm_q;

endmodule
